// File: rtl/keypad_code_lock.sv
// keypad_code_lock
//   Keypad front end for the door-entry path. The key lines are priority-encoded
//   (highest index wins), each press is debounced, and exactly one digit is
//   recorded per press into a DEPTH-digit buffer. Once the buffer is full:
//     - ENTRY mode (mode = 0) compares it with the stored code and pulses match or mismatch.
//     - PROGRAM mode (mode = 1) overwrites the stored code and pulses prog_done.
//
//   Optional feature macro: KCL_LOCKOUT_EN
//     When defined, MAX_FAILS consecutive mismatches set a sticky lockout.
//     While locked, presses are ignored. Only rst clears the lockout.
//
// Ports
//   clk        in   posedge clock
//   rst        in   asynchronous, active-high reset
//   key_in     in   [NUM_KEYS-1:0] synchronised key lines, 1 = pressed
//   mode       in   0 = ENTRY, 1 = PROGRAM
//   clear      in   discard the partial entry
//   digit      out  [DIGIT_W-1:0] last accepted digit
//   digit_vld  out  one-cycle pulse per accepted digit
//   count      out  digits currently buffered
//   match      out  one-cycle pulse, entered code equals stored code
//   mismatch   out  one-cycle pulse, entered code differs from stored code
//   prog_done  out  one-cycle pulse, stored code updated
//   locked     out  lockout active (constant 0 without KCL_LOCKOUT_EN)
module keypad_code_lock #(
   parameter int NUM_KEYS  = 10,
   parameter int DIGIT_W   = 4,
   parameter int DEPTH     = 4,
   parameter int DEBOUNCE  = 4,
   parameter int MAX_FAILS = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_KEYS-1:0]            key_in,
   input  logic                           mode,
   input  logic                           clear,
   output logic [DIGIT_W-1:0]             digit,
   output logic                           digit_vld,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           match,
   output logic                           mismatch,
   output logic                           prog_done,
   output logic                           locked
);

   localparam int CW    = $clog2(DEPTH + 1);
   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DEBNC = 2'd1,
      HELD  = 2'd2
   } state_t;

   // Elaboration-time parameter sanity checks
   if (NUM_KEYS > (2 ** DIGIT_W)) begin : g_chk_keys
      $error("keypad_code_lock: NUM_KEYS does not fit in DIGIT_W");
   end
   if (DEBOUNCE < 1) begin : g_chk_debounce
      $error("keypad_code_lock: DEBOUNCE must be at least 1");
   end
   if (MAX_FAILS < 1) begin : g_chk_max_fails
      $error("keypad_code_lock: MAX_FAILS must be at least 1");
   end

   // Highest pressed key index wins
   function automatic logic [DIGIT_W-1:0] prio_enc(input logic [NUM_KEYS-1:0] k);
      logic [DIGIT_W-1:0] enc;
      enc = {DIGIT_W{1'b0}};
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (k[i]) begin
            enc = DIGIT_W'(i);
         end
      end
      return enc;
   endfunction

   state_t                          state_r, next_state_s;
   logic [NUM_KEYS-1:0]             sample_r;
   logic [CNT_W-1:0]                dcnt_r;
   logic                            load_s, inc_s, accept_s;
   logic                            key_idle_s, toggle_s, cmp_s, equal_s;
   logic [DEPTH-1:0][DIGIT_W-1:0]   buf_r, code_r;
   logic [CW-1:0]                   count_r;
   logic [DIGIT_W-1:0]              digit_r;
   logic                            digit_vld_r, match_r, mismatch_r, prog_done_r;
   logic                            mode_r, locked_r;

   assign key_idle_s = (key_in == {NUM_KEYS{1'b0}});
   assign toggle_s   = (mode != mode_r);
   // A mode change abandons the entry, so it also suppresses a pending compare
   assign cmp_s      = !toggle_s && (count_r == CW'(DEPTH));
   assign equal_s    = (buf_r == code_r);

   // Debounce FSM state register and key sample/counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         sample_r <= {NUM_KEYS{1'b0}};
         dcnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (load_s) begin
            sample_r <= key_in;
            dcnt_r   <= CNT_W'(1);
         end else if (inc_s) begin
            dcnt_r <= dcnt_r + CNT_W'(1);
         end else begin
            dcnt_r <= dcnt_r;
         end
      end
   end

   // Debounce FSM next-state and control decode
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      inc_s        = 1'b0;
      accept_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (!locked_r && !key_idle_s) begin
               next_state_s = DEBNC;
               load_s       = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         DEBNC: begin
            if (locked_r || key_idle_s) begin
               next_state_s = IDLE;
            end else if (key_in != sample_r) begin
               load_s = 1'b1;
            end else if (dcnt_r == CNT_W'(DEBOUNCE)) begin
               // Counter already reached DEBOUNCE on a stable sample: accept now
               accept_s     = 1'b1;
               next_state_s = HELD;
            end else begin
               inc_s = 1'b1;
            end
         end
         HELD: begin
            if (key_idle_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = HELD;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Digit buffer, stored code, compare/program and registered pulse outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_r       <= {(DEPTH * DIGIT_W){1'b0}};
         code_r      <= {(DEPTH * DIGIT_W){1'b0}};
         count_r     <= {CW{1'b0}};
         digit_r     <= {DIGIT_W{1'b0}};
         digit_vld_r <= 1'b0;
         match_r     <= 1'b0;
         mismatch_r  <= 1'b0;
         prog_done_r <= 1'b0;
         mode_r      <= 1'b0;
      end else begin
         mode_r      <= mode;
         digit_vld_r <= accept_s;
         match_r     <= 1'b0;
         mismatch_r  <= 1'b0;
         prog_done_r <= 1'b0;
         if (accept_s) begin
            digit_r <= prio_enc(sample_r);
         end else begin
            digit_r <= digit_r;
         end
         if (toggle_s) begin
            count_r <= {CW{1'b0}};
         end else if (cmp_s) begin
            // Full buffer: report or program regardless of clear; count always restarts
            count_r <= {CW{1'b0}};
            if (mode) begin
               code_r      <= buf_r;
               prog_done_r <= 1'b1;
            end else if (equal_s) begin
               match_r <= 1'b1;
            end else begin
               mismatch_r <= 1'b1;
            end
         end else if (clear) begin
            count_r <= {CW{1'b0}};
         end else if (accept_s) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (count_r == CW'(i)) begin
                  buf_r[i] <= prio_enc(sample_r);
               end
            end
            count_r <= count_r + CW'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end

`ifdef KCL_LOCKOUT_EN
   localparam int FW = $clog2(MAX_FAILS + 1);
   logic [FW-1:0] fail_r;

   // Consecutive-mismatch counter and sticky lockout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_r   <= {FW{1'b0}};
         locked_r <= 1'b0;
      end else if (cmp_s && !mode) begin
         if (equal_s) begin
            fail_r <= {FW{1'b0}};
         end else begin
            if (fail_r < FW'(MAX_FAILS)) begin
               fail_r <= fail_r + FW'(1);
            end else begin
               fail_r <= fail_r;
            end
            if (fail_r >= FW'(MAX_FAILS - 1)) begin
               locked_r <= 1'b1;
            end else begin
               locked_r <= locked_r;
            end
         end
      end else begin
         fail_r   <= fail_r;
         locked_r <= locked_r;
      end
   end
`else
   assign locked_r = 1'b0;
`endif

   assign digit     = digit_r;
   assign digit_vld = digit_vld_r;
   assign count     = count_r;
   assign match     = match_r;
   assign mismatch  = mismatch_r;
   assign prog_done = prog_done_r;
   assign locked    = locked_r;

endmodule
